slink_tx_sched: RTL and testbench

//  Frame scheduler/arbiter in front of the slink TX PCS encoder and PMATX serializer.

---
 rtl/slink_pkg.sv | 20 ++
 rtl/slink_rr_arb.sv | 43 ++++
 rtl/slink_tx_sched.sv | 169 ++++++++++++++++
 tb/tb_slink_tx_sched.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/slink_pkg.sv
// rtl/slink_pkg.sv - shared constants and FSM encoding for the slink TX scheduler
package slink_pkg;

    localparam logic [7:0] K_COMMA = 8'hBC;  // K28.5
    localparam logic [7:0] K_SOF   = 8'hFB;  // K27.7
    localparam logic [7:0] K_EOF   = 8'hFD;  // K29.7
    localparam logic [7:0] K_ABORT = 8'hFE;  // K30.7

    localparam int SYM_PERIOD_DEF = 10;
    localparam int IFG_W          = 8;

    // An abort is a one-slot outcome of SOF/PAYLOAD, so it needs no state of its own.
    typedef enum logic [1:0] {
        S_IDLE,
        S_SOF,
        S_PAYLOAD,
        S_EOF
    } tx_state_e;

endpackage

// File: rtl/slink_rr_arb.sv
// rtl/slink_rr_arb.sv - round-robin winner select over the requesters, with last-grant register
module slink_rr_arb #(
    parameter int NUM_SRC = 2,
    parameter int IDX_W   = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_SRC-1:0] req_i,
    input  logic               upd_i,
    input  logic [IDX_W-1:0]   upd_idx_i,
    output logic               win_vld_o,
    output logic [IDX_W-1:0]   win_idx_o
);

    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] last_d;
    logic [IDX_W-1:0] cand;

    assign last_d = upd_i ? upd_idx_i : last_q;

    // Reset to the highest index so source 0 is first in line.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= IDX_W'(NUM_SRC - 1);
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        win_vld_o = 1'b0;
        win_idx_o = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = IDX_W'((int'(last_q) + k) % NUM_SRC);
            if (!win_vld_o && req_i[cand]) begin
                win_vld_o = 1'b1;
                win_idx_o = cand;
            end
        end
    end

endmodule

// File: rtl/slink_tx_sched.sv
// rtl/slink_tx_sched.sv - slot-aligned frame scheduler sharing one serial lane among requesters
module slink_tx_sched
    import slink_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int SYM_PERIOD = SYM_PERIOD_DEF,
    parameter int IFG_SYM    = 4
) (
    input  logic                 clk_125m,
    input  logic                 rst_125m,
    input  logic                 link_en,
    input  logic [NUM_SRC-1:0]   src_req,
    input  logic [NUM_SRC*8-1:0] src_len,
    input  logic [NUM_SRC*8-1:0] src_data,
    output logic [NUM_SRC-1:0]   src_gnt,
    output logic [NUM_SRC-1:0]   src_rd,
    output logic [NUM_SRC-1:0]   src_done,
    output logic [7:0]           tx_byte,
    output logic                 tx_is_k,
    output logic                 tx_sym_stb,
    output logic                 frm_abort
);

    localparam int IDX_W  = $clog2(NUM_SRC);
    localparam int SLOT_W = $clog2(SYM_PERIOD);

    logic [SLOT_W-1:0]  slot_cnt_q, slot_cnt_d;
    tx_state_e          state_q, state_d;
    logic [IDX_W-1:0]   g_q, g_d;
    logic [7:0]         len_q, len_d;
    logic [IFG_W-1:0]   ifg_q, ifg_d;
    logic               frm_abort_q, frm_abort_d;
    logic [7:0]         tx_byte_q, tx_byte_d;
    logic               tx_is_k_q, tx_is_k_d;
    logic               tx_sym_stb_q;
    logic [NUM_SRC-1:0] gnt_q, gnt_d;
    logic [NUM_SRC-1:0] rd_q, rd_d;
    logic [NUM_SRC-1:0] done_q, done_d;

    logic               tick;
    logic               abort_c;
    logic [NUM_SRC-1:0] gsel;
    logic [7:0]         cur_len;
    logic [7:0]         cur_data;
    logic               arb_upd;
    logic               win_vld;
    logic [IDX_W-1:0]   win_idx;

    slink_rr_arb #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_arb (
        .clk_i     (clk_125m),
        .rst_i     (rst_125m),
        .req_i     (src_req),
        .upd_i     (arb_upd),
        .upd_idx_i (g_q),
        .win_vld_o (win_vld),
        .win_idx_o (win_idx)
    );

    assign slot_cnt_d = (slot_cnt_q == SLOT_W'(SYM_PERIOD - 1)) ? '0 : slot_cnt_q + 1'b1;
    // Decide one clock early so every registered output lands in the slot_cnt==SYM_PERIOD-1 cycle.
    assign tick       = (slot_cnt_q == SLOT_W'(SYM_PERIOD - 2));
    assign cur_len    = src_len[int'(g_q)*8 +: 8];
    assign cur_data   = src_data[int'(g_q)*8 +: 8];
    assign abort_c    = !link_en || !src_req[g_q];

    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        len_d       = len_q;
        ifg_d       = ifg_q;
        frm_abort_d = frm_abort_q;
        tx_byte_d   = tx_byte_q;
        tx_is_k_d   = tx_is_k_q;
        gnt_d       = gnt_q;
        rd_d        = '0;
        done_d      = '0;
        arb_upd     = 1'b0;
        gsel        = '0;
        gsel[g_q]   = 1'b1;

        if (tick) begin
            gnt_d     = '0;
            tx_byte_d = K_COMMA;
            tx_is_k_d = 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (ifg_q != '0) ifg_d = ifg_q - 1'b1;
                    // Grant on the comma that brings the gap count to zero.
                    if ((ifg_q <= IFG_W'(1)) && link_en && win_vld) begin
                        g_d     = win_idx;
                        state_d = S_SOF;
                    end
                end
                S_SOF, S_PAYLOAD: begin
                    gnt_d = gsel;
                    if (state_q == S_SOF) arb_upd = 1'b1;
                    if (abort_c) begin
                        tx_byte_d   = K_ABORT;
                        done_d      = gsel;
                        frm_abort_d = 1'b1;
                        ifg_d       = IFG_W'(IFG_SYM);
                        state_d     = S_IDLE;
                    end else if (state_q == S_SOF) begin
                        tx_byte_d   = K_SOF;
                        len_d       = cur_len;
                        frm_abort_d = 1'b0;
                        state_d     = (cur_len != 8'd0) ? S_PAYLOAD : S_EOF;
                    end else begin
                        tx_byte_d = cur_data;
                        tx_is_k_d = 1'b0;
                        rd_d      = gsel;
                        len_d     = len_q - 1'b1;
                        if (len_q == 8'd1) state_d = S_EOF;
                    end
                end
                S_EOF: begin
                    gnt_d     = gsel;
                    tx_byte_d = K_EOF;
                    done_d    = gsel;
                    ifg_d     = IFG_W'(IFG_SYM);
                    state_d   = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_125m or posedge rst_125m) begin
        if (rst_125m) begin
            slot_cnt_q   <= '0;
            state_q      <= S_IDLE;
            g_q          <= '0;
            len_q        <= '0;
            ifg_q        <= IFG_W'(IFG_SYM);
            frm_abort_q  <= 1'b0;
            tx_byte_q    <= K_COMMA;
            tx_is_k_q    <= 1'b1;
            tx_sym_stb_q <= 1'b0;
            gnt_q        <= '0;
            rd_q         <= '0;
            done_q       <= '0;
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            state_q      <= state_d;
            g_q          <= g_d;
            len_q        <= len_d;
            ifg_q        <= ifg_d;
            frm_abort_q  <= frm_abort_d;
            tx_byte_q    <= tx_byte_d;
            tx_is_k_q    <= tx_is_k_d;
            tx_sym_stb_q <= tick;
            gnt_q        <= gnt_d;
            rd_q         <= rd_d;
            done_q       <= done_d;
        end
    end

    assign src_gnt    = gnt_q;
    assign src_rd     = rd_q;
    assign src_done   = done_q;
    assign tx_byte    = tx_byte_q;
    assign tx_is_k    = tx_is_k_q;
    assign tx_sym_stb = tx_sym_stb_q;
    assign frm_abort  = frm_abort_q;

endmodule

// File: tb/tb_slink_tx_sched.sv
// tb/tb_slink_tx_sched.sv - randomized bench for slink_tx_sched against a symbol-plan reference model
module tb_slink_tx_sched;
    import slink_pkg::*;

    localparam int NS      = 2;
    localparam int P       = 10;
    localparam int IFG     = 4;
    localparam int SYM_SOF = -1;
    localparam int SYM_EOF = -2;

    logic            clk = 1'b0;
    logic            rst;
    logic            link_en;
    logic [NS-1:0]   src_req;
    logic [NS*8-1:0] src_len;
    logic [NS*8-1:0] src_data;
    logic [NS-1:0]   src_gnt;
    logic [NS-1:0]   src_rd;
    logic [NS-1:0]   src_done;
    logic [7:0]      tx_byte;
    logic            tx_is_k;
    logic            tx_sym_stb;
    logic            frm_abort;

    always #5 clk = ~clk;

    slink_tx_sched #(
        .NUM_SRC    (NS),
        .SYM_PERIOD (P),
        .IFG_SYM    (IFG)
    ) dut (
        .clk_125m   (clk),
        .rst_125m   (rst),
        .link_en    (link_en),
        .src_req    (src_req),
        .src_len    (src_len),
        .src_data   (src_data),
        .src_gnt    (src_gnt),
        .src_rd     (src_rd),
        .src_done   (src_done),
        .tx_byte    (tx_byte),
        .tx_is_k    (tx_is_k),
        .tx_sym_stb (tx_sym_stb),
        .frm_abort  (frm_abort)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Source-side behaviour: one head frame per source.
    int has[NS], wd[NS], hlen[NS], hseed[NS], ptr[NS], cool[NS];
    int big_left = 2;

    // Reference model: expected symbol plan of the open frame plus gap and RR bookkeeping.
    int   plan[$];
    int   m_own, m_last, m_gap;
    logic m_abort;

    int   since, have_prev, saw_rd;

    function automatic logic [7:0] mkbyte(input int seed, input int k);
        return 8'(seed * 37 + k * 13 + 5);
    endfunction

    task automatic new_frame(input int i);
        int r;
        r = int'($urandom_range(0, 15));
        if (r < 3) hlen[i] = 0;
        else if (r == 3 && big_left > 0) begin
            hlen[i] = 255;
            big_left--;
        end else hlen[i] = int'($urandom_range(1, 6));
        hseed[i] = int'($urandom_range(0, 255));
        has[i]   = 1;
        ptr[i]   = 0;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NS; i++) begin
            src_req[i]        = (has[i] != 0) && (wd[i] == 0);
            src_len[i*8 +: 8] = (has[i] != 0) ? 8'(hlen[i]) : 8'h00;
            src_data[i*8 +: 8] = (has[i] != 0 && ptr[i] < hlen[i]) ? mkbyte(hseed[i], ptr[i]) : 8'h00;
        end
    endtask

    task automatic model_reset();
        plan.delete();
        m_gap   = 0;
        m_last  = NS - 1;
        m_own   = 0;
        m_abort = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_byte"}, tx_byte, K_COMMA);
        chk({tag, "_isk"}, tx_is_k, 1);
        chk({tag, "_stb"}, tx_sym_stb, 0);
        chk({tag, "_gnt"}, src_gnt, 0);
        chk({tag, "_rd"}, src_rd, 0);
        chk({tag, "_done"}, src_done, 0);
        chk({tag, "_abort"}, frm_abort, 0);
    endtask

    task automatic on_slot();
        logic [7:0]    eb;
        logic          ek;
        logic [NS-1:0] eg, erd, edn;
        int            sym, cand, found;
        eb = K_COMMA; ek = 1'b1; eg = '0; erd = '0; edn = '0;
        if (plan.size() > 0) begin
            sym       = plan.pop_front();
            eg[m_own] = 1'b1;
            if (sym == SYM_SOF) m_last = m_own;
            if (sym != SYM_EOF && (!link_en || !src_req[m_own])) begin
                eb = K_ABORT; edn[m_own] = 1'b1; m_abort = 1'b1; plan.delete(); m_gap = 0;
            end else if (sym == SYM_SOF) begin
                eb = K_SOF; m_abort = 1'b0;
            end else if (sym == SYM_EOF) begin
                eb = K_EOF; edn[m_own] = 1'b1; m_gap = 0;
            end else begin
                eb = 8'(sym); ek = 1'b0; erd[m_own] = 1'b1;
            end
        end else begin
            m_gap++;
            if (m_gap >= IFG && link_en && (src_req != '0)) begin
                found = 0;
                for (int k = 1; k <= NS; k++) begin
                    cand = (m_last + k) % NS;
                    if (found == 0 && src_req[cand]) begin
                        found = 1;
                        m_own = cand;
                    end
                end
                plan.push_back(SYM_SOF);
                for (int b = 0; b < hlen[m_own]; b++) plan.push_back(int'(mkbyte(hseed[m_own], b)));
                plan.push_back(SYM_EOF);
            end
        end

        chk("tx_byte", tx_byte, eb);
        chk("tx_is_k", tx_is_k, ek);
        chk("src_gnt", src_gnt, eg);
        chk("src_rd", src_rd, erd);
        chk("src_done", src_done, edn);
        chk("frm_abort", frm_abort, m_abort);
        if (src_rd != '0) saw_rd = 1;

        for (int i = 0; i < NS; i++) begin
            if (src_done[i]) begin
                has[i] = 0; wd[i] = 0; ptr[i] = 0;
                if ($urandom_range(0, 3) != 0) new_frame(i);
                else cool[i] = int'($urandom_range(1, 12));
            end else begin
                if (src_rd[i]) ptr[i]++;
                if (has[i] == 0) begin
                    if (cool[i] > 0) cool[i]--;
                    else new_frame(i);
                end else if (src_gnt[i] && $urandom_range(0, 29) == 0) begin
                    wd[i] = 1;
                end
            end
        end
        link_en = ($urandom_range(0, 49) != 0);
        drive_inputs();
    endtask

    task automatic step();
        @(negedge clk);
        since++;
        if (tx_sym_stb) begin
            if (have_prev != 0) chk("stb_period", since, P);
            have_prev = 1;
            since     = 0;
            on_slot();
        end else begin
            chk("pulse_off_slot", {src_rd, src_done}, 0);
        end
    endtask

    initial begin
        rst     = 1'b1;
        link_en = 1'b1;
        for (int i = 0; i < NS; i++) begin
            has[i] = 0; wd[i] = 0; ptr[i] = 0; hlen[i] = 0; hseed[i] = 0;
            cool[i] = 8 + 2 * i;
        end
        model_reset();
        drive_inputs();
        have_prev = 0; since = 0; saw_rd = 0;
        repeat (3) @(negedge clk);
        check_reset("por");
        rst = 1'b0;

        for (int c = 0; c < 9000; c++) step();

        saw_rd = 0;
        for (int c = 0; c < 4000 && saw_rd == 0; c++) step();
        chk("rst_wait_payload", saw_rd, 1);
        #2 rst = 1'b1;
        #1 check_reset("rst_mid");
        @(negedge clk);
        check_reset("rst_hold");
        rst     = 1'b0;
        link_en = 1'b1;
        for (int i = 0; i < NS; i++) begin
            ptr[i] = 0;
            wd[i]  = 0;
        end
        model_reset();
        drive_inputs();
        have_prev = 0; since = 0;

        for (int c = 0; c < 3000; c++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
